stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM and prescaler that sequences the stopwatch counter datapath.
- Converts single-cycle user command pulses (start/stop, lap, clear) into the counter's per-tick enable, clear strobe and display-freeze signal.
- Divides the 100 MHz board clock down to the stopwatch resolution tick.
- Sits between the debounced button logic and the stopwatch counter/display chain.

Parameters:
- TICK_DIV, 1000000: clock cycles per count tick (100 MHz / 1000000 = 10 ms). Minimum 2.
- PW, $clog2(TICK_DIV): prescaler width. Derived, not overridden.

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_rst  in  1  synchronous, active-high reset.
- i_start_stop  in  1  single-cycle, debounced start/stop command.
- i_lap  in  1  single-cycle lap command.
- i_clear  in  1  single-cycle clear command.
- i_cnt_done  in  1  high while the counter sits at its terminal value.
- o_tick  out  1  one-cycle counter increment enable.
- o_clr  out  1  one-cycle counter clear strobe.
- o_hold  out  1  display freeze; high only in LAP.
- o_running  out  1  high in RUN or LAP.
- o_overflow  out  1  sticky terminal-count flag.
- o_state  out  2  IDLE=00, RUN=01, PAUSE=10, LAP=11.

Behaviour:
Clock and reset:
- Single clock domain. All outputs are registered.
- Reset is synchronous and active-high on i_clk.
- While i_rst is high, on the next edge: state=IDLE, prescaler=0, and all outputs = 0.

Prescaler:
- Advances only in RUN or LAP.
- Is held, not cleared, in PAUSE, so a resume completes the interrupted period exactly.
- Is zeroed on entering IDLE and on reset.
- At the edge where prescaler==TICK_DIV-1 in RUN/LAP:
  - prescaler wraps to 0 ("wrap edge");
  - o_tick=1 for the following cycle only, unless overflow suppression applies.
- The first o_tick is high in the cycle that starts TICK_DIV edges after the edge that entered RUN.

Command priority when pulses coincide: i_clear > i_start_stop > i_lap. The lower-priority pulse is dropped.

State transitions:
- IDLE:
  - start_stop -> RUN, prescaler=0.
  - clear -> stay IDLE, o_clr=1 for one cycle.
  - lap is ignored.
- RUN:
  - start_stop -> PAUSE.
  - lap -> LAP; o_hold=1 from the next cycle.
  - clear is ignored.
- LAP (counting continues, ticks keep issuing):
  - lap -> RUN; o_hold=0.
  - start_stop -> PAUSE; o_hold=0.
  - clear is ignored.
- PAUSE:
  - start_stop -> RUN if o_overflow=0; ignored if o_overflow=1.
  - clear -> IDLE, o_clr=1 for one cycle, o_overflow=0, prescaler=0.
  - lap is ignored.

Overflow:
- Applies at a wrap edge in RUN/LAP with i_cnt_done=1.
- Effect: o_tick is suppressed, state -> PAUSE, o_hold=0, o_overflow=1 (sticky).
- The counter is never advanced past its terminal value.
- Overflow takes precedence over a start_stop or lap pulse on the same edge.

Output definitions:
- o_running = state is RUN or LAP, registered with the state.
- o_state mirrors the state register.

Reset mid-operation:
- Reset overrides everything on its edge.
- Any pending o_tick or o_clr is cancelled.
- o_clr is NOT asserted by reset; the counter has its own reset.

Test Plan:
(All scenarios use TICK_DIV=4.)
1. Reset behaviour: assert i_rst for 2 cycles with random command pulses -> o_state=00 and all outputs 0 throughout; commands during reset have no effect.
2. Tick cadence: i_start_stop at edge E0, then run 20 cycles -> o_state=01 and o_running=1 after E0; o_tick high exactly in cycles 4, 8, 12, 16, 20 after E0 (5 pulses, each 1 cycle wide).
3. Pause/resume: start, pause 6 edges later (prescaler=2), wait 10 cycles with no o_tick, resume -> next o_tick 2 cycles after the resume edge, then every 4 cycles.
4. Lap: in RUN, pulse i_lap -> o_state=11 and o_hold=1 while ticks continue every 4 cycles; second i_lap -> o_state=01 and o_hold=0; i_lap followed by i_start_stop -> o_state=10 and o_hold=0.
5. Overflow: in RUN, hold i_cnt_done=1 -> at the first wrap no o_tick, o_state=10, o_overflow=1; i_start_stop ignored; i_clear -> o_state=00, o_clr high one cycle, o_overflow=0.
6. Priority and reset: in PAUSE, i_clear and i_start_stop on the same cycle -> IDLE plus o_clr, no RUN; i_clear in RUN -> ignored, no o_clr; i_rst mid-RUN -> o_state=00 next cycle, no o_clr.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control FSM and prescaler for the stopwatch counter datapath. Single-cycle
// user commands (start/stop, lap, clear) from the debounced button logic are
// turned into the counter's per-tick increment enable, its clear strobe and
// the display-freeze signal. The board clock is divided by TICK_DIV to form
// the stopwatch resolution tick.
//
// Parameters:
//   TICK_DIV  clock cycles per count tick (minimum 2)
//   PW        prescaler width, derived from TICK_DIV
//
// Ports:
//   i_clk         system clock (100 MHz)
//   i_rst         synchronous, active-high reset
//   i_start_stop  single-cycle start/stop command
//   i_lap         single-cycle lap command
//   i_clear       single-cycle clear command
//   i_cnt_done    high while the counter sits at its terminal value
//   o_tick        one-cycle counter increment enable
//   o_clr         one-cycle counter clear strobe
//   o_hold        display freeze, high only in LAP
//   o_running     high in RUN or LAP
//   o_overflow    sticky terminal-count flag
//   o_state       IDLE=00, RUN=01, PAUSE=10, LAP=11
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1000000,
    localparam int PW = $clog2(TICK_DIV)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start_stop,
    input  logic       i_lap,
    input  logic       i_clear,
    input  logic       i_cnt_done,
    output logic       o_tick,
    output logic       o_clr,
    output logic       o_hold,
    output logic       o_running,
    output logic       o_overflow,
    output logic [1:0] o_state
);

    // State encoding is externally visible on o_state.
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_d;
    logic          clr_d;
    logic          ovf_d;

    // -------------------------------------------------------------------------
    // Command decode. Coinciding pulses are resolved up front with
    // clear > start_stop > lap; the losing pulse is dropped even when the
    // winner has no effect in the current state.
    // -------------------------------------------------------------------------
    logic cmd_clr;
    logic cmd_ss;
    logic cmd_lap;

    assign cmd_clr = i_clear;
    assign cmd_ss  = i_start_stop & ~i_clear;
    assign cmd_lap = i_lap & ~i_start_stop & ~i_clear;

    // -------------------------------------------------------------------------
    // Prescaler status. The prescaler only advances while counting; a wrap
    // edge is the edge on which it rolls from TICK_DIV-1 back to 0.
    // -------------------------------------------------------------------------
    logic counting;
    logic wrap;
    logic overflow_hit;

    assign counting     = (state_q == S_RUN) || (state_q == S_LAP);
    assign wrap         = counting && (presc_q == PRESC_LAST);
    // Issuing a tick here would push the counter past its terminal value.
    assign overflow_hit = wrap && i_cnt_done;

    // -------------------------------------------------------------------------
    // Next-state, prescaler and strobe logic.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clr_d   = 1'b0;
        ovf_d   = o_overflow;

        case (state_q)
            S_IDLE: begin
                // Held at zero so every start begins a full period.
                presc_d = '0;
                if (cmd_clr) begin
                    clr_d = 1'b1;
                end else if (cmd_ss) begin
                    state_d = S_RUN;
                end
            end

            S_RUN, S_LAP: begin
                presc_d = wrap ? '0 : presc_q + 1'b1;
                if (overflow_hit) begin
                    // Overflow beats any command arriving on the same edge.
                    state_d = S_PAUSE;
                    ovf_d   = 1'b1;
                end else begin
                    // A wrap coinciding with a stop still delivers its tick:
                    // the period it closes was fully timed.
                    tick_d = wrap;
                    if (cmd_ss) begin
                        state_d = S_PAUSE;
                    end else if (cmd_lap) begin
                        state_d = (state_q == S_RUN) ? S_LAP : S_RUN;
                    end
                end
            end

            S_PAUSE: begin
                // Prescaler is held so a resume finishes the interrupted
                // period exactly.
                if (cmd_clr) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    clr_d   = 1'b1;
                    ovf_d   = 1'b0;
                end else if (cmd_ss && !o_overflow) begin
                    state_d = S_RUN;
                end
            end

            default: begin
                state_d = S_IDLE;
                presc_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. All outputs are registered alongside the state so they
    // change together on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            // Reset cancels any pending strobe; the counter has its own
            // reset, so o_clr stays low here.
            state_q    <= S_IDLE;
            presc_q    <= '0;
            o_tick     <= 1'b0;
            o_clr      <= 1'b0;
            o_hold     <= 1'b0;
            o_running  <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            o_tick     <= tick_d;
            o_clr      <= clr_d;
            o_hold     <= (state_d == S_LAP);
            o_running  <= (state_d == S_RUN) || (state_d == S_LAP);
            o_overflow <= ovf_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed bench for stopwatch_ctrl with TICK_DIV=4. The stimulus process
// issues commands and pushes the expected o_tick / o_clr events (kind and
// cycle) into a queue; a monitor pops and compares whenever the DUT raises
// one of those strobes. Level outputs are checked directly by the stimulus
// process one time unit after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;

    localparam logic [1:0] EV_TICK = 2'b10;
    localparam logic [1:0] EV_CLR  = 2'b01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss = 1'b0;
    logic       lap = 1'b0;
    logic       clr = 1'b0;
    logic       cnt_done = 1'b0;
    logic       o_tick;
    logic       o_clr;
    logic       o_hold;
    logic       o_running;
    logic       o_overflow;
    logic [1:0] o_state;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start_stop(ss),
        .i_lap       (lap),
        .i_clear     (clr),
        .i_cnt_done  (cnt_done),
        .o_tick      (o_tick),
        .o_clr       (o_clr),
        .o_hold      (o_hold),
        .o_running   (o_running),
        .o_overflow  (o_overflow),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge k settles, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] kind;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] all_outs();
        return {25'b0, o_tick, o_clr, o_hold, o_running, o_overflow, o_state};
    endfunction

    // Level outputs: {hold, running, overflow, state}.
    task automatic chk(input string name, input logic [1:0] st, input logic run,
                       input logic hold, input logic ovf);
        check(name, {27'b0, o_hold, o_running, o_overflow, o_state},
                    {27'b0, hold, run, ovf, st});
    endtask

    task automatic push(input logic [1:0] kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Present a command for exactly one edge; e returns that edge's number.
    task automatic cmd(input logic s, input logic l, input logic c, output int e);
        ss  = s;
        lap = l;
        clr = c;
        @(posedge clk);
        #1;
        e   = cyc;
        ss  = 1'b0;
        lap = 1'b0;
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe the DUT raises must match the head of the queue.
    always @(negedge clk) begin
        if (o_tick === 1'b1 || o_clr === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'b0, o_tick, o_clr}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", {30'b0, o_tick, o_clr}, {30'b0, mon_e.kind});
                check("event_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int e;
        int er;

        // ---- 1. Reset with random command pulses --------------------------
        rst = 1'b1;
        repeat (2) begin
            ss  = 1'($urandom_range(0, 1));
            lap = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("reset_outs", all_outs(), 32'd0);
        end
        ss  = 1'b0;
        lap = 1'b0;
        clr = 1'b0;
        rst = 1'b0;
        idle(2);
        check("idle_after_reset", all_outs(), 32'd0);

        // ---- 2. Tick cadence ----------------------------------------------
        cmd(1'b1, 1'b0, 1'b0, e0);
        chk("s2_run", S_RUN, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) push(EV_TICK, e0 + 4 * k);
        idle(10);
        chk("s2_still_run", S_RUN, 1'b1, 1'b0, 1'b0);
        idle(9);
        cmd(1'b1, 1'b0, 1'b0, e);          // stop on the edge-20 wrap
        chk("s2_pause", S_PAUSE, 1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1, e);
        push(EV_CLR, e);
        chk("s2_idle", S_IDLE, 1'b0, 1'b0, 1'b0);

        // ---- 3. Pause / resume keeps prescaler phase ----------------------
        cmd(1'b1, 1'b0, 1'b0, e0);
        push(EV_TICK, e0 + 4);
        idle(5);
        cmd(1'b1, 1'b0, 1'b0, e);          // pause at e0+6, prescaler=2
        chk("s3_pause", S_PAUSE, 1'b0, 1'b0, 1'b0);
        idle(10);
        chk("s3_still_pause", S_PAUSE, 1'b0, 1'b0, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, er);
        push(EV_TICK, er + 2);
        push(EV_TICK, er + 6);
        push(EV_TICK, er + 10);
        chk("s3_resume", S_RUN, 1'b1, 1'b0, 1'b0);
        idle(9);
        cmd(1'b1, 1'b0, 1'b0, e);
        cmd(1'b0, 1'b0, 1'b1, e);
        push(EV_CLR, e);

        // ---- 4. Lap -------------------------------------------------------
        cmd(1'b1, 1'b0, 1'b0, e0);
        push(EV_TICK, e0 + 4);
        push(EV_TICK, e0 + 8);
        push(EV_TICK, e0 + 12);
        idle(1);
        cmd(1'b0, 1'b1, 1'b0, e);          // e0+2
        chk("s4_lap", S_LAP, 1'b1, 1'b1, 1'b0);
        idle(7);
        chk("s4_lap_held", S_LAP, 1'b1, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0, e);          // e0+10
        chk("s4_back_run", S_RUN, 1'b1, 1'b0, 1'b0);
        cmd(1'b0, 1'b1, 1'b0, e);          // e0+11
        chk("s4_lap_again", S_LAP, 1'b1, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, e);          // e0+12, wrap + stop
        chk("s4_lap_pause", S_PAUSE, 1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1, e);
        push(EV_CLR, e);

        // ---- 5. Overflow --------------------------------------------------
        cnt_done = 1'b1;
        cmd(1'b1, 1'b0, 1'b0, e0);
        idle(3);
        chk("s5_pre_wrap", S_RUN, 1'b1, 1'b0, 1'b0);
        idle(1);                           // wrap edge e0+4, no tick
        chk("s5_overflow", S_PAUSE, 1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0, e);
        chk("s5_resume_blocked", S_PAUSE, 1'b0, 1'b0, 1'b1);
        cnt_done = 1'b0;
        cmd(1'b0, 1'b0, 1'b1, e);
        push(EV_CLR, e);
        chk("s5_cleared", S_IDLE, 1'b0, 1'b0, 1'b0);

        // ---- 6. Priority and reset mid-run --------------------------------
        cmd(1'b1, 1'b0, 1'b0, e0);
        cmd(1'b0, 1'b0, 1'b1, e);          // clear ignored in RUN
        chk("s6_clear_ignored", S_RUN, 1'b1, 1'b0, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, e);          // e0+2 -> PAUSE
        cmd(1'b1, 1'b0, 1'b1, e);          // clear wins over start_stop
        push(EV_CLR, e);
        chk("s6_clear_wins", S_IDLE, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("s6_no_run", S_IDLE, 1'b0, 1'b0, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, e0);
        idle(3);
        rst = 1'b1;                        // reset lands on the wrap edge
        idle(1);
        check("s6_reset_mid_run", all_outs(), 32'd0);
        rst = 1'b0;
        idle(6);
        check("s6_after_reset", all_outs(), 32'd0);

        idle(4);
        check("pending_events", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
